ped_request_conditioner: RTL

Front-end for the pedestrian push-button that feeds the traffic-light controller's `P` input.
- Synchronizes the raw, bouncing, asynchronous button into `clk`, debounces it with a saturating counter FSM, and detects presses.
- Drives `P` toward the controller: either a latched request held until the controller acknowledges service, or the debounced level.
- Sits between the board button pin and the controller, in the same clock domain as the controller.

---
 rtl/ped_request_conditioner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button front end: 2-flop synchronizer, saturating-counter debounce FSM,
// press pulse/counter and request output. Define PED_REQ_LATCH_EN to latch P until ack.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             ack,
  output logic             P,
  output logic             btn_level,
  output logic             press_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(0);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_LOW_CHK  = 2'd1,
    ST_HIGH     = 2'd2,
    ST_HIGH_CHK = 2'd3
  } db_state_e;

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Debounce next-state: any cycle agreeing with the stable level restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_LOW_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_LOW_CHK: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_LOW_CHK;
          cnt_d   = cnt_q + DB_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_HIGH_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_HIGH_CHK: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_HIGH_CHK;
          cnt_d   = cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so level, pulse and count all land on the flip edge.
  always_comb begin
    level_d = (state_d == ST_HIGH) || (state_d == ST_HIGH_CHK);
    pulse_d = (state_q == ST_LOW_CHK) && (state_d == ST_HIGH);
    if (pulse_d) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Synchronizer, debounce state and press bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_q;
  assign press_pulse = pulse_q;
  assign press_count = count_q;

`ifdef PED_REQ_LATCH_EN
  logic req_q, req_d;

  // Set on the pulse edge and held through the pulse cycle, so an ack seen alongside
  // the pulse cannot drop a fresh press.
  always_comb begin
    if (pulse_d || pulse_q) begin
      req_d = 1'b1;
    end else if (ack) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q;
    end
  end

  // Request latch register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign P = req_q;
`else
  logic unused_ack_s;
  assign unused_ack_s = ack;
  assign P = level_q;
`endif

endmodule
